// File: rtl/exc_pkg.sv
// Shared constants, enums and lookup tables for the ARM7 exception entry sequencer.
// Used by exc_prio_enc and exc_entry_seq.
package exc_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  localparam logic [2:0] DR_R14  = 3'd0;
  localparam logic [2:0] DR_PC   = 3'd1;
  localparam logic [2:0] DR_CPSR = 3'd2;
  localparam logic [2:0] DR_SPSR = 3'd3;

  // Bit positions of the sticky pulse-request register
  localparam int NPEND      = 4;
  localparam int PEND_DABT  = 0;
  localparam int PEND_PABT  = 1;
  localparam int PEND_UNDEF = 2;
  localparam int PEND_SWI   = 3;

  typedef enum logic [2:0] {EXC_NONE, DABT, FIQ, IRQ, PABT, UNDEF, SWI} exc_e;

  typedef enum logic [2:0] {IDLE, SAVE_SPSR, WRITE_LR, SET_CPSR, LOAD_PC, ACK} state_e;

  function automatic logic [31:0] lr_ofs(input exc_e e);
    case (e)
      DABT:             lr_ofs = 32'd8;
      FIQ, IRQ, PABT:   lr_ofs = 32'd4;
      default:          lr_ofs = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] vec_ofs(input exc_e e);
    case (e)
      UNDEF:   vec_ofs = 32'h04;
      SWI:     vec_ofs = 32'h08;
      PABT:    vec_ofs = 32'h0C;
      DABT:    vec_ofs = 32'h10;
      IRQ:     vec_ofs = 32'h18;
      FIQ:     vec_ofs = 32'h1C;
      default: vec_ofs = 32'h00;
    endcase
  endfunction

  function automatic logic [4:0] target_mode(input exc_e e);
    case (e)
      FIQ:        target_mode = MODE_FIQ;
      IRQ:        target_mode = MODE_IRQ;
      SWI:        target_mode = MODE_SVC;
      DABT, PABT: target_mode = MODE_ABT;
      UNDEF:      target_mode = MODE_UND;
      default:    target_mode = MODE_USR;
    endcase
  endfunction

  // One-hot sticky bit owned by a pulse-type exception (zero for fiq/irq)
  function automatic logic [NPEND-1:0] pend_mask(input exc_e e);
    pend_mask = '0;
    case (e)
      DABT:    pend_mask[PEND_DABT]  = 1'b1;
      PABT:    pend_mask[PEND_PABT]  = 1'b1;
      UNDEF:   pend_mask[PEND_UNDEF] = 1'b1;
      SWI:     pend_mask[PEND_SWI]   = 1'b1;
      default: pend_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational masking and fixed-priority encode of pending exceptions.
// Priority: dabt > fiq > irq > pabt > undef > swi.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [NPEND-1:0] pend,
  input  logic             fiq,
  input  logic             irq,
  input  logic             f_mask,
  input  logic             i_mask,
  output exc_e             winner
);

  always_comb begin
    winner = EXC_NONE;
    if (pend[PEND_DABT])       winner = DABT;
    else if (fiq && !f_mask)   winner = FIQ;
    else if (irq && !i_mask)   winner = IRQ;
    else if (pend[PEND_PABT])  winner = PABT;
    else if (pend[PEND_UNDEF]) winner = UNDEF;
    else if (pend[PEND_SWI])   winner = SWI;
  end

endmodule

// File: rtl/exc_entry_seq.sv
// ARM7 exception entry sequencer: captures the winning exception at an instruction
// boundary, then writes SPSR, R14, CPSR and PC through the reg bank. EXC_HIVEC_EN selects high vectors.
module exc_entry_seq
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_boundary,
  input  logic        fiq,
  input  logic        irq,
  input  logic        dabt_req,
  input  logic        pabt_req,
  input  logic        undef_req,
  input  logic        swi_req,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] pc_in,
  output logic        busy,
  output logic        exc_ack,
  output logic        LD_reg,
  output logic [2:0]  DRMUX,
  output logic [4:0]  M,
  output logic [31:0] wr_data
);

`ifdef EXC_HIVEC_EN
  localparam bit HIVEC = 1'b1;
`else
  localparam bit HIVEC = 1'b0;
`endif
  localparam logic [31:0] BASE = HIVEC ? 32'hFFFF_0000 : VEC_BASE;

  state_e           state_reg, state_next;
  exc_e             exc_reg;
  logic [31:0]      cpsr_cap_reg;
  logic [31:0]      pc_cap_reg;
  logic [NPEND-1:0] pend_reg, pend_next;

  logic [NPEND-1:0] pulse, pend_eff, clr;
  exc_e             winner;
  logic             capture;
  logic [4:0]       tmode;

  assign pulse    = {swi_req, undef_req, pabt_req, dabt_req};
  assign pend_eff = pend_reg | pulse;

  exc_prio_enc u_prio (
    .pend   (pend_eff),
    .fiq    (fiq),
    .irq    (irq),
    .f_mask (cpsr_in[6]),
    .i_mask (cpsr_in[7]),
    .winner (winner)
  );

  assign capture = (state_reg == IDLE) && instr_boundary && (winner != EXC_NONE);
  assign clr     = capture ? pend_mask(winner) : '0;

  // A captured bit survives only if it was already pending and a fresh pulse
  // lands in the same cycle; a pulse that is itself being serviced is consumed.
  for (genvar gi = 0; gi < NPEND; gi++) begin : g_pend
    assign pend_next[gi] = clr[gi] ? (pend_reg[gi] & pulse[gi]) : pend_eff[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      pend_reg     <= '0;
      exc_reg      <= EXC_NONE;
      cpsr_cap_reg <= '0;
      pc_cap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      if (capture) begin
        exc_reg      <= winner;
        cpsr_cap_reg <= cpsr_in;
        pc_cap_reg   <= pc_in;
      end
    end
  end

  assign tmode = target_mode(exc_reg);

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    exc_ack    = 1'b0;
    LD_reg     = 1'b0;
    DRMUX      = DR_R14;
    M          = tmode;
    wr_data    = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        M    = cpsr_in[4:0];
        if (capture) state_next = SAVE_SPSR;
      end
      SAVE_SPSR: begin
        LD_reg     = 1'b1;
        DRMUX      = DR_SPSR;
        wr_data    = cpsr_cap_reg;
        state_next = WRITE_LR;
      end
      WRITE_LR: begin
        LD_reg     = 1'b1;
        DRMUX      = DR_R14;
        wr_data    = pc_cap_reg + lr_ofs(exc_reg);
        state_next = SET_CPSR;
      end
      SET_CPSR: begin
        LD_reg     = 1'b1;
        DRMUX      = DR_CPSR;
        wr_data    = {cpsr_cap_reg[31:8], 1'b1,
                      (exc_reg == FIQ) | cpsr_cap_reg[6], 1'b0, tmode};
        state_next = LOAD_PC;
      end
      LOAD_PC: begin
        LD_reg     = 1'b1;
        DRMUX      = DR_PC;
        wr_data    = BASE + vec_ofs(exc_reg);
        state_next = ACK;
      end
      ACK: begin
        exc_ack    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        M          = cpsr_in[4:0];
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_entry_seq.sv
// Scoreboard bench for exc_entry_seq: a cycle-level reference model queues the expected
// reg-bank writes and ack at each capture; a negedge monitor pops and compares.
module tb_exc_entry_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_boundary, fiq, irq, dabt_req, pabt_req, undef_req, swi_req;
  logic [31:0] cpsr_in, pc_in;
  logic        busy, exc_ack, LD_reg;
  logic [2:0]  DRMUX;
  logic [4:0]  M;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  exc_entry_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_boundary (instr_boundary),
    .fiq            (fiq),
    .irq            (irq),
    .dabt_req       (dabt_req),
    .pabt_req       (pabt_req),
    .undef_req      (undef_req),
    .swi_req        (swi_req),
    .cpsr_in        (cpsr_in),
    .pc_in          (pc_in),
    .busy           (busy),
    .exc_ack        (exc_ack),
    .LD_reg         (LD_reg),
    .DRMUX          (DRMUX),
    .M              (M),
    .wr_data        (wr_data)
  );

`ifdef EXC_HIVEC_EN
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif

  typedef struct {
    bit          ack;
    logic [2:0]  dr;
    logic [4:0]  m;
    logic [31:0] data;
    int          cyc;
    string       tag;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   exp_busy = 1'b0;
  int   busy_left = 0;
  bit   pend[4];   // 0 dabt, 1 pabt, 2 undef, 3 swi

  // Exception kinds: 1 dabt, 2 fiq, 3 irq, 4 pabt, 5 undef, 6 swi
  logic [31:0] lr_tab  [7] = '{32'd0, 32'd8, 32'd4, 32'd4, 32'd4, 32'd0, 32'd0};
  logic [31:0] vec_tab [7] = '{32'h0, 32'h10, 32'h1C, 32'h18, 32'h0C, 32'h04, 32'h08};
  logic [4:0]  mode_tab[7] = '{5'b10000, 5'b10111, 5'b10001, 5'b10010, 5'b10111, 5'b11011, 5'b10011};
  int          sync_bit[7] = '{-1, 0, -1, -1, 1, 2, 3};

  task automatic push_rec(input bit ack, input logic [2:0] dr, input logic [4:0] m,
                          input logic [31:0] data, input int c, input string tag);
    rec_t r;
    r.ack = ack; r.dr = dr; r.m = m; r.data = data; r.cyc = c; r.tag = tag;
    exp_q.push_back(r);
  endtask

  task automatic push_seq(input int k, input logic [31:0] cpsr, input logic [31:0] pc);
    logic [31:0] nc;
    logic [4:0]  m;
    m  = mode_tab[k];
    nc = cpsr;
    nc[7] = 1'b1;
    if (k == 2) nc[6] = 1'b1;
    nc[5]   = 1'b0;
    nc[4:0] = m;
    push_rec(1'b0, 3'd3, m, cpsr,                 cyc + 1, "spsr");
    push_rec(1'b0, 3'd0, m, pc + lr_tab[k],       cyc + 2, "r14");
    push_rec(1'b0, 3'd2, m, nc,                   cyc + 3, "cpsr");
    push_rec(1'b0, 3'd1, m, BASE + vec_tab[k],    cyc + 4, "pc");
    push_rec(1'b1, 3'd0, m, 32'h0,                cyc + 5, "ack");
  endtask

  // One clock period of stimulus plus the reference model's view of that period.
  task automatic step(input bit bnd, input bit f, input bit i, input bit da, input bit pa,
                      input bit un, input bit sw, input logic [31:0] cpsr, input logic [31:0] pc);
    bit p[4];
    bit eff[4];
    int k;
    @(posedge clk);
    #1;
    cyc++;
    instr_boundary = bnd; fiq = f; irq = i;
    dabt_req = da; pabt_req = pa; undef_req = un; swi_req = sw;
    cpsr_in = cpsr; pc_in = pc;
    p = '{da, pa, un, sw};
    for (int j = 0; j < 4; j++) eff[j] = pend[j] | p[j];
    exp_busy = (busy_left > 0);
    k = 0;
    if (busy_left > 0) busy_left--;
    else if (bnd) begin
      if (eff[0])                 k = 1;
      else if (f && !cpsr[6])     k = 2;
      else if (i && !cpsr[7])     k = 3;
      else if (eff[1])            k = 4;
      else if (eff[2])            k = 5;
      else if (eff[3])            k = 6;
    end
    if (k != 0) begin
      push_seq(k, cpsr, pc);
      busy_left = 5;
    end
    for (int j = 0; j < 4; j++)
      pend[j] = (k != 0 && sync_bit[k] == j) ? (pend[j] & p[j]) : eff[j];
  endtask

  task automatic idle(input int n, input bit bnd);
    for (int j = 0; j < n; j++) step(bnd, 0, 0, 0, 0, 0, 0, 32'h10, 32'h1000);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cyc++;
    instr_boundary = 0; fiq = 0; irq = 0;
    dabt_req = 0; pabt_req = 0; undef_req = 0; swi_req = 0;
    exp_q.delete();
    busy_left = 0;
    exp_busy  = 1'b0;
    for (int j = 0; j < 4; j++) pend[j] = 1'b0;
    for (int j = 1; j < n; j++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    rec_t r;
    bit   ok;
    if (!reset_n) begin
      total++;
      if (busy !== 1'b0 || LD_reg !== 1'b0 || exc_ack !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d busy=%b LD_reg=%b exc_ack=%b required all 0",
                 cyc, busy, LD_reg, exc_ack);
      end
    end else begin
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, exp_busy);
      end
      if (LD_reg === 1'b1 || exc_ack === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output cyc=%0d LD_reg=%b exc_ack=%b DRMUX=%0d M=%b data=%h required none",
                   cyc, LD_reg, exc_ack, DRMUX, M, wr_data);
        end else begin
          r = exp_q.pop_front();
          if (r.ack)
            ok = (exc_ack === 1'b1) && (LD_reg === 1'b0) && (M === r.m) && (cyc == r.cyc);
          else
            ok = (LD_reg === 1'b1) && (exc_ack === 1'b0) && (DRMUX === r.dr) &&
                 (M === r.m) && (wr_data === r.data) && (cyc == r.cyc);
          if (!ok) begin
            bad++;
            $display("FAIL %s cyc=%0d got LD=%b ack=%b DRMUX=%0d M=%b data=%h required cyc=%0d DRMUX=%0d M=%b data=%h",
                     r.tag, cyc, LD_reg, exc_ack, DRMUX, M, wr_data, r.cyc, r.dr, r.m, r.data);
          end else begin
            $display("txn cyc=%0d %s DRMUX=%0d M=%b data=%h", cyc, r.tag, DRMUX, M, wr_data);
          end
        end
      end else begin
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          total++;
          bad++;
          r = exp_q.pop_front();
          $display("FAIL missed_%s cyc=%0d got no output required data=%h at cyc=%0d",
                   r.tag, cyc, r.data, r.cyc);
        end
        if (!exp_busy) begin
          total++;
          if (DRMUX !== 3'd0 || wr_data !== 32'h0 || M !== cpsr_in[4:0]) begin
            bad++;
            $display("FAIL idle_outputs cyc=%0d DRMUX=%0d wr_data=%h M=%b required 0/0/%b",
                     cyc, DRMUX, wr_data, M, cpsr_in[4:0]);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    instr_boundary = 0; fiq = 0; irq = 0;
    dabt_req = 0; pabt_req = 0; undef_req = 0; swi_req = 0;
    cpsr_in = 32'h10; pc_in = 32'h0;
    for (int j = 0; j < 4; j++) pend[j] = 1'b0;
    #2 reset_n = 1'b0;
    do_reset(3);
    idle(2, 1'b1);

    // IRQ taken from USR mode
    step(1, 0, 1, 0, 0, 0, 0, 32'h10, 32'h100);
    idle(7, 1'b0);

    // IRQ masked by the I bit: never taken
    for (int j = 0; j < 10; j++) step(1, 0, 1, 0, 0, 0, 0, 32'h90, 32'h100);

    // dabt pulse and fiq at the same boundary: dabt first, then fiq
    step(1, 1, 0, 1, 0, 0, 0, 32'h10, 32'h300);
    for (int j = 0; j < 7; j++) step(1, 1, 0, 0, 0, 0, 0, 32'h10, 32'h340);
    idle(6, 1'b0);

    // swi pulse while busy is serviced after ACK
    step(1, 0, 1, 0, 0, 0, 0, 32'h10, 32'h400);
    step(0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h400);
    step(0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h400);
    idle(10, 1'b1);

    // Already-pending undef re-pulsed in its capture cycle stays pending
    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 32'h500);
    step(1, 0, 0, 0, 0, 1, 0, 32'h10, 32'h504);
    idle(12, 1'b1);

    // pc + LR offset wraps at 2^32
    step(1, 0, 0, 1, 0, 0, 0, 32'h10, 32'hFFFF_FFFC);
    idle(6, 1'b0);

    // Reset during WRITE_LR aborts the sequence and clears a pending undef
    step(1, 0, 1, 0, 0, 0, 0, 32'h10, 32'h200);
    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 32'h200);
    do_reset(2);
    idle(8, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom, $urandom);
    end
    idle(10, 1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain outstanding=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
